// File: rtl/data_memory_ctrl.sv
// Word-addressed data memory with byte-lane writes and a simple request/ready
// handshake. After reset the array is cleared one word per cycle (INIT), then
// single requests are served with a programmable number of wait states (ACCESS).
module data_memory_ctrl #(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 8,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [ADDR_WIDTH-1:0]   address,
   input  logic [DATA_WIDTH-1:0]   writeData,
   input  logic [DATA_WIDTH/8-1:0] byteEnable,
   input  logic                    MemRead,
   input  logic                    MemWrite,
   output logic [DATA_WIDTH-1:0]   dataOut,
   output logic                    ready,
   output logic                    readValid,
   output logic                    busy,
   output logic                    error
);

   localparam int LANES = DATA_WIDTH / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [3:0]          WAIT_INIT = 4'(WAIT_STATES);

   typedef enum logic [1:0] {INIT, IDLE, ACCESS} stateT;

   stateT                 stateReg;
   logic [IDX_W-1:0]      clearIdx;
   logic [3:0]            waitCnt;
   logic [ADDR_WIDTH-1:0] addrReg;
   logic [DATA_WIDTH-1:0] dataReg;
   logic [LANES-1:0]      laneReg;
   logic                  opWriteReg;
   logic                  readyReg;
   logic                  busyReg;
   logic                  readValidReg;
   logic                  errorReg;

   // Memory-port control, derived from the FSM state. Reset gates both the
   // clearing writes and the completion so an aborted access leaves no trace.
   logic                  addrInRange;
   logic [IDX_W-1:0]      addrIdx;
   logic                  clearEn;
   logic                  finishEn;
   logic                  wrEn;
   logic                  rdEn;
   logic [IDX_W-1:0]      wrIdx;
   logic [LANES-1:0]      wrLanes;
   logic [DATA_WIDTH-1:0] wrWord;

   assign addrInRange = ({1'b0, addrReg} < DEPTH_LIM);
   assign addrIdx     = addrReg[IDX_W-1:0];
   assign clearEn     = (stateReg == INIT) && !reset;
   assign finishEn    = (stateReg == ACCESS) && (waitCnt == 4'd0) && !reset;
   assign wrEn        = clearEn || (finishEn && opWriteReg && addrInRange);
   assign rdEn        = finishEn && !opWriteReg;
   assign wrIdx       = clearEn ? clearIdx : addrIdx;
   assign wrLanes     = clearEn ? {LANES{1'b1}} : laneReg;
   assign wrWord      = clearEn ? '0 : dataReg;

   // Control FSM: init sweep, request acceptance, wait-state countdown, completion.
   always_ff @(posedge clock) begin
      if (reset) begin
         stateReg     <= INIT;
         clearIdx     <= '0;
         waitCnt      <= 4'd0;
         addrReg      <= '0;
         dataReg      <= '0;
         laneReg      <= '0;
         opWriteReg   <= 1'b0;
         readyReg     <= 1'b0;
         busyReg      <= 1'b1;
         readValidReg <= 1'b0;
         errorReg     <= 1'b0;
      end else begin
         readValidReg <= 1'b0;
         errorReg     <= 1'b0;
         case (stateReg)
            INIT: begin
               clearIdx <= clearIdx + 1'b1;
               if (clearIdx == LAST_IDX) begin
                  stateReg <= IDLE;
                  readyReg <= 1'b1;
                  busyReg  <= 1'b0;
               end
            end
            IDLE: begin
               if (MemRead ^ MemWrite) begin
                  addrReg    <= address;
                  dataReg    <= writeData;
                  laneReg    <= byteEnable;
                  opWriteReg <= MemWrite;
                  waitCnt    <= WAIT_INIT;
                  stateReg   <= ACCESS;
                  readyReg   <= 1'b0;
               end else if (MemRead && MemWrite) begin
                  errorReg <= 1'b1;
               end
            end
            ACCESS: begin
               if (waitCnt != 4'd0) begin
                  waitCnt <= waitCnt - 4'd1;
               end else begin
                  stateReg     <= IDLE;
                  readyReg     <= 1'b1;
                  readValidReg <= !opWriteReg;
                  errorReg     <= !addrInRange;
               end
            end
            default: begin
               stateReg <= INIT;
               clearIdx <= '0;
               readyReg <= 1'b0;
               busyReg  <= 1'b1;
            end
         endcase
      end
   end

   // One narrow RAM per byte lane so each lane has its own write enable.
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : gLane
         logic [7:0] laneMem [DEPTH];
         logic [7:0] laneOut;

         // Byte-lane write port (clearing sweep or masked completion write).
         always_ff @(posedge clock) begin
            if (wrEn && wrLanes[gi]) begin
               laneMem[wrIdx] <= wrWord[8*gi +: 8];
            end
         end

         // Registered read port; holds until the next read, zero when out of range.
         always_ff @(posedge clock) begin
            if (reset) begin
               laneOut <= 8'h00;
            end else if (rdEn) begin
               laneOut <= addrInRange ? laneMem[addrIdx] : 8'h00;
            end
         end

         assign dataOut[8*gi +: 8] = laneOut;
      end
   endgenerate

   assign ready     = readyReg;
   assign busy      = busyReg;
   assign readValid = readValidReg;
   assign error     = errorReg;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench: instance 0 runs with no wait states, instance 1 with two.
// Stimulus pushes expected read/error events; a negedge monitor pops and compares.
module tb_data_memory_ctrl;

   logic        clk = 1'b0;
   logic        rst [2];
   logic [7:0]  addr [2];
   logic [15:0] wd [2];
   logic [1:0]  be [2];
   logic        mr [2];
   logic        mw [2];
   logic [15:0] dOut [2];
   logic        rdy [2];
   logic        rv [2];
   logic        bsy [2];
   logic        er [2];

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        rv;
      logic [15:0] data;
      logic        er;
   } expT;

   expT q0[$];
   expT q1[$];

   always #5 clk = ~clk;

   data_memory_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(16), .WAIT_STATES(0)) dut0 (
      .clock(clk), .reset(rst[0]), .address(addr[0]), .writeData(wd[0]), .byteEnable(be[0]),
      .MemRead(mr[0]), .MemWrite(mw[0]), .dataOut(dOut[0]), .ready(rdy[0]),
      .readValid(rv[0]), .busy(bsy[0]), .error(er[0]));

   data_memory_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(16), .WAIT_STATES(2)) dut1 (
      .clock(clk), .reset(rst[1]), .address(addr[1]), .writeData(wd[1]), .byteEnable(be[1]),
      .MemRead(mr[1]), .MemWrite(mw[1]), .dataOut(dOut[1]), .ready(rdy[1]),
      .readValid(rv[1]), .busy(bsy[1]), .error(er[1]));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic push(input int d, input logic v, input logic [15:0] data, input logic e);
      expT x;
      x.rv = v; x.data = data; x.er = e;
      if (d == 0) q0.push_back(x); else q1.push_back(x);
   endtask

   // Monitor: every readValid or error pulse must match the oldest expectation.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rv[d] || er[d]) begin
            expT x;
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
               total++;
               bad++;
               $display("FAIL unexpected_event dut%0d: rv=%0b err=%0b with nothing expected", d, rv[d], er[d]);
            end else begin
               if (d == 0) x = q0.pop_front(); else x = q1.pop_front();
               chk("mon_readValid", rv[d], x.rv);
               chk("mon_error", er[d], x.er);
               if (x.rv) chk("mon_dataOut", dOut[d], x.data);
            end
         end
      end
   end

   // One accepted request; checks ready timing and, when poke is set, wiggles
   // inputs during the access to show they do not affect it.
   task automatic issue(input int d, input logic rd, input logic wr, input logic [7:0] a,
                        input logic [15:0] w, input logic [1:0] b,
                        input logic [15:0] expData, input logic expErr, input logic poke);
      int ws;
      ws = (d == 0) ? 0 : 2;
      @(negedge clk);
      addr[d] = a; wd[d] = w; be[d] = b; mr[d] = rd; mw[d] = wr;
      if (rd) push(d, 1'b1, expData, expErr);
      else if (expErr) push(d, 1'b0, 16'h0000, 1'b1);
      @(posedge clk);
      #1;
      mr[d] = 1'b0; mw[d] = 1'b0;
      if (poke) begin
         mw[d] = 1'b1; addr[d] = a + 8'd2; wd[d] = 16'hFFFF; be[d] = 2'b11;
      end
      for (int j = 0; j <= ws; j++) begin
         @(negedge clk);
         chk("ready_low", rdy[d], 1'b0);
      end
      @(negedge clk);
      chk("ready_back", rdy[d], 1'b1);
      chk("readValid_timing", rv[d], rd);
      mw[d] = 1'b0;
      $display("txn dut%0d rd=%0b wr=%0b addr=%0d wdata=%h be=%b exp=%h experr=%0b",
               d, rd, wr, a, w, b, expData, expErr);
   endtask

   task automatic bothReq(input int d, input logic [7:0] a, input logic [15:0] holdData);
      @(negedge clk);
      addr[d] = a; wd[d] = 16'h7777; be[d] = 2'b11; mr[d] = 1'b1; mw[d] = 1'b1;
      push(d, 1'b0, 16'h0000, 1'b1);
      @(posedge clk);
      #1;
      mr[d] = 1'b0; mw[d] = 1'b0;
      @(negedge clk);
      chk("both_ready_stays", rdy[d], 1'b1);
      chk("both_dataOut_held", dOut[d], holdData);
      $display("txn dut%0d rd=1 wr=1 addr=%0d rejected", d, a);
   endtask

   task automatic waitReady(input int d, output int n);
      n = 0;
      while (!rdy[d] && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("ready_timeout", rdy[d], 1'b1);
   endtask

   initial begin
      int n;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; addr[d] = '0; wd[d] = '0; be[d] = '0; mr[d] = 1'b0; mw[d] = 1'b0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_busy", bsy[d], 1'b1);
         chk("rst_ready", rdy[d], 1'b0);
         chk("rst_dataOut", dOut[d], 16'h0000);
         chk("rst_readValid", rv[d], 1'b0);
         chk("rst_error", er[d], 1'b0);
      end
      rst[0] = 1'b0; rst[1] = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         if (i == 15) begin
            chk("init_busy_15", bsy[0], 1'b1);
            chk("init_ready_15", rdy[0], 1'b0);
         end
         if (i == 16) begin
            chk("init_busy_16", bsy[0], 1'b0);
            chk("init_ready_16", rdy[0], 1'b1);
            chk("init_ready_16_dut1", rdy[1], 1'b1);
         end
      end

      // Instance 0: cleared memory, byte-lane writes, rejects and out-of-range.
      for (int a = 0; a < 16; a++) issue(0, 1'b1, 1'b0, 8'(a), 16'h0, 2'b00, 16'h0000, 1'b0, 1'b0);
      issue(0, 1'b0, 1'b1, 8'd3, 16'hABCD, 2'b11, 16'h0, 1'b0, 1'b0);
      issue(0, 1'b1, 1'b0, 8'd3, 16'h0, 2'b00, 16'hABCD, 1'b0, 1'b0);
      issue(0, 1'b0, 1'b1, 8'd3, 16'h1200, 2'b10, 16'h0, 1'b0, 1'b0);
      issue(0, 1'b1, 1'b0, 8'd3, 16'h0, 2'b00, 16'h12CD, 1'b0, 1'b0);
      issue(0, 1'b0, 1'b1, 8'd3, 16'hFFFF, 2'b00, 16'h0, 1'b0, 1'b0);
      issue(0, 1'b1, 1'b0, 8'd3, 16'h0, 2'b00, 16'h12CD, 1'b0, 1'b0);
      bothReq(0, 8'd3, 16'h12CD);
      issue(0, 1'b1, 1'b0, 8'd3, 16'h0, 2'b00, 16'h12CD, 1'b0, 1'b0);
      issue(0, 1'b1, 1'b0, 8'd20, 16'h0, 2'b00, 16'h0000, 1'b1, 1'b0);
      issue(0, 1'b0, 1'b1, 8'd20, 16'h9999, 2'b11, 16'h0, 1'b1, 1'b0);
      chk("dataOut_held_after_err_write", dOut[0], 16'h0000);
      issue(0, 1'b1, 1'b0, 8'd4, 16'h0, 2'b00, 16'h0000, 1'b0, 1'b0);

      // Instance 1: wait states, ignored mid-access requests, reset abort.
      issue(1, 1'b0, 1'b1, 8'd3, 16'h1234, 2'b11, 16'h0, 1'b0, 1'b0);
      issue(1, 1'b1, 1'b0, 8'd3, 16'h0, 2'b00, 16'h1234, 1'b0, 1'b1);
      issue(1, 1'b1, 1'b0, 8'd5, 16'h0, 2'b00, 16'h0000, 1'b0, 1'b0);
      issue(1, 1'b1, 1'b0, 8'd3, 16'h0, 2'b00, 16'h1234, 1'b0, 1'b0);

      @(negedge clk);
      addr[1] = 8'd7; wd[1] = 16'h5555; be[1] = 2'b11; mw[1] = 1'b1;
      @(posedge clk);
      #1;
      mw[1] = 1'b0;
      @(negedge clk);
      chk("abort_in_access", rdy[1], 1'b0);
      rst[1] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_busy", bsy[1], 1'b1);
      chk("abort_ready", rdy[1], 1'b0);
      chk("abort_dataOut", dOut[1], 16'h0000);
      rst[1] = 1'b0;
      $display("txn dut1 write addr=7 data=5555 aborted by reset");
      waitReady(1, n);
      chk("reinit_cycles", 32'(n), 32'd16);
      issue(1, 1'b1, 1'b0, 8'd7, 16'h0, 2'b00, 16'h0000, 1'b0, 1'b0);
      issue(1, 1'b1, 1'b0, 8'd3, 16'h0, 2'b00, 16'h0000, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(q0.size() + q1.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
